if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch front end; the initiator for the combinational instruction ROM.
- Drives the ROM's chip enable and byte address, and takes the instruction returned in the same cycle.
- Advances the PC, honours pipeline stalls, branch redirects and exception flushes.
- Registers the {pc, inst, valid, adel} bundle into the IF/ID pipeline register that feeds decode.

Parameters:
- ADDR_W, 32, PC/ROM byte-address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction injected on bubble or flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC and ROM request.
- stall_id  in  1  hold the IF/ID register contents.
- flush  in  1  exception/eret redirect, highest priority after rst.
- new_pc  in  ADDR_W  flush target.
- branch_flag_i  in  1  taken branch/jump from ID.
- branch_target_i  in  ADDR_W  branch target.
- inst_i  in  INST_W  ROM data for the current rom_addr (combinational).
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  ADDR_W  ROM byte address (equals pc).
- id_pc  out  ADDR_W  registered PC to decode.
- id_inst  out  INST_W  registered instruction to decode.
- id_valid  out  1  id_pc/id_inst carry a real fetch.
- id_adel  out  1  fetch-address-misaligned exception tag.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: rom_ce=0, pc=RESET_PC, id_pc=0, id_inst=NOP_INST, id_valid=0, id_adel=0.
- PC state machine, two states:
  - IDLE (rom_ce=0) is entered on rst and always moves to RUN on the next cycle.
  - In RUN, rom_ce=1. The first RUN cycle presents RESET_PC.
  - rst asserted mid-RUN returns to IDLE on that edge and discards any in-flight fetch.
- Next-PC priority in RUN: flush, then stall_if, then branch_flag_i, then sequential.
  - flush: pc <= new_pc.
  - stall_if: pc holds.
  - branch_flag_i: pc <= branch_target_i. The delay-slot instruction is already in the fetch slot and is not killed.
  - Otherwise: pc <= pc + 4, wrapping modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- branch_flag_i is sampled only when stall_if=0. ID holds it stable across stalls. A branch coinciding with flush is dropped.
- ROM interface: rom_addr = pc combinationally. inst_i is valid in the same cycle (zero latency).
- Misaligned address: if pc[1:0] != 0 while rom_ce=1, that fetch is tagged adel=1 and its inst is replaced by NOP_INST. The PC sequence is unaffected; the exception unit issues flush.
- IF/ID register update rules:
  - rst or flush: clear to NOP_INST, valid=0, adel=0.
  - stall_if=1 and stall_id=0: insert a bubble (NOP_INST, valid=0) and keep id_pc.
  - stall_id=1: hold all fields.
  - Otherwise: capture {pc, inst_i, rom_ce, adel}.
- Latency: an instruction at address A appears on id_* one edge after rom_addr=A is presented unstalled.
- Simultaneous events:
  - flush together with stall_if/stall_id: flush wins; the PC redirects and IF/ID clears.
  - stall_id=1 with stall_if=0 is illegal (stall vector is monotonic). The bench asserts it never occurs; RTL treats it as stall_if=1.

Decomposition:
- Shared constants go in defines.vh: RstEnable, ChipEnable/ChipDisable, ZeroWord, InstAddrBus, InstBus, Stop/NoStop, and an IF_IDLE/IF_RUN state encoding.
- One sub-module: pc_reg, covering the state machine, next-PC mux and rom_ce/rom_addr.
- if_stage instantiates pc_reg and holds the IF/ID register and the alignment check.

Test Plan:
- Reset release:
  - Stimulus: rst high 3 cycles, then low.
  - Required: rom_ce=0 during reset; first cycle after release rom_ce=1, rom_addr=0x0; then 0x4, 0x8; id_pc lags one cycle with id_valid=1.
- Stall bubble:
  - Stimulus: stall_if=1, stall_id=0 for 2 cycles at pc=0x10.
  - Required: rom_addr holds 0x10; id_inst=NOP_INST, id_valid=0 for 2 cycles; resume with id_pc=0x10.
- Branch with delay slot:
  - Stimulus: branch_flag_i=1, target 0x100 while pc=0x0C.
  - Required: id sequence 0x0C, 0x100, 0x104; no kill of 0x0C.
- Flush priority:
  - Stimulus: flush=1, new_pc=0x180 together with stall_if=1 and branch_flag_i=1.
  - Required: next rom_addr=0x180; id_valid=0 next cycle.
- Misaligned fetch:
  - Stimulus: branch to 0x102.
  - Required: id_pc=0x102, id_adel=1, id_inst=NOP_INST.
- Wrap and mid-run reset:
  - Stimulus: flush to 0xFFFF_FFFC, then run one cycle, then rst for 1 cycle.
  - Required: rom_addr 0xFFFF_FFFC then 0x0; after rst, rom_ce=0 and id_valid=0, then restart at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

  // Instruction fetches must be word aligned.
  function automatic logic fetch_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC sequencer: IDLE/RUN state machine, next-PC mux, ROM enable and address.
// rom_addr is the PC itself (zero latency); stall holds the PC, flush overrides stall.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter int               ADDR_W   = InstAddrBus,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IF_IDLE: begin
        state_d = IF_RUN;
        pc_d    = RESET_PC;
      end
      IF_RUN: begin
        // A branch is only honoured on an unstalled cycle; flush drops it.
        if (flush) begin
          pc_d = new_pc;
        end else if (stall == NoStop) begin
          if (branch_flag_i) begin
            pc_d = branch_target_i;
          end else begin
            pc_d = pc_q + ADDR_W'(4);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign rom_ce   = (state_q == IF_RUN) ? ChipEnable : ChipDisable;
  assign rom_addr = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM and registers {pc, inst, valid, adel} into IF/ID.
// One edge from unstalled rom_addr to id_*; stall_if inserts bubbles, stall_id holds IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ZeroWord),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(ZeroWord)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  // stall_id without stall_if is not a legal stall vector; fold it into a PC stall.
  logic pc_stall;
  assign pc_stall = stall_if | stall_id;

  if_stage_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall           (pc_stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce          (rom_ce),
    .rom_addr        (rom_addr)
  );

  logic fetch_adel;
  assign fetch_adel = (rom_ce == ChipEnable) && fetch_misaligned(rom_addr[1:0]);

  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              id_adel_q, id_adel_d;

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      id_pc_d    = ADDR_W'(ZeroWord);
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (stall_id == Stop) begin
      // decode is stalled: keep its view unchanged
    end else if (stall_if == Stop) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else begin
      id_pc_d    = rom_addr;
      id_inst_d  = fetch_adel ? NOP_INST : inst_i;
      id_valid_d = rom_ce;
      id_adel_d  = fetch_adel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      id_pc_q    <= ADDR_W'(ZeroWord);
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_if, stall_id, flush, branch_flag_i;
  logic [31:0] new_pc, branch_target_i, inst_i;
  logic        rom_ce, id_valid, id_adel;
  logic [31:0] rom_addr, id_pc, id_inst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_stage #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_i          (inst_i),
    .rom_ce          (rom_ce),
    .rom_addr        (rom_addr),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_valid        (id_valid),
    .id_adel         (id_adel)
  );

  // ROM contents: a fixed scramble of the address, never equal to NOP for these tests.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_comb inst_i = rom_fn(rom_addr);

  // Reference model: "running" flag, current PC, and the view decode sees.
  bit          m_run;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  bit          m_id_valid, m_id_adel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          misaligned;
    logic [31:0] fetched;
    if (rst) begin
      m_run = 0; m_pc = RESET_PC;
      m_id_pc = 32'h0; m_id_inst = NOP_INST; m_id_valid = 0; m_id_adel = 0;
      return;
    end
    misaligned = m_run && (m_pc % 4 != 0);
    fetched    = misaligned ? NOP_INST : rom_fn(m_pc);
    if (flush) begin
      m_id_pc = 32'h0; m_id_inst = NOP_INST; m_id_valid = 0; m_id_adel = 0;
    end else if (stall_id) begin
      // decode holds what it has
    end else if (stall_if) begin
      m_id_inst = NOP_INST; m_id_valid = 0; m_id_adel = 0;
    end else begin
      m_id_pc = m_pc; m_id_inst = fetched; m_id_valid = m_run; m_id_adel = misaligned;
    end
    if (!m_run) begin
      m_run = 1; m_pc = RESET_PC;
    end else if (flush) begin
      m_pc = new_pc;
    end else if (stall_if || stall_id) begin
      // PC held
    end else if (branch_flag_i) begin
      m_pc = branch_target_i;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    check("rom_ce",   {31'b0, rom_ce},   {31'b0, m_run});
    check("rom_addr", rom_addr,          m_pc);
    check("id_pc",    id_pc,             m_id_pc);
    check("id_inst",  id_inst,           m_id_inst);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    check("id_adel",  {31'b0, id_adel},  {31'b0, m_id_adel});
  endtask

  // One clock: apply inputs after the falling edge, update at the rising edge, compare at the next fall.
  task automatic cyc(input bit r, input bit sif, input bit sid, input bit fl,
                     input logic [31:0] npc, input bit br, input logic [31:0] tgt);
    rst = r; stall_if = sif; stall_id = sid; flush = fl;
    new_pc = npc; branch_flag_i = br; branch_target_i = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run1();
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; stall_if = 0; stall_id = 0; flush = 0;
    new_pc = 0; branch_flag_i = 0; branch_target_i = 0;
    @(negedge clk);

    // Reset release
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
      check("rst_ce", {31'b0, rom_ce}, 32'h0);
    end
    run1();
    check("rel_ce", {31'b0, rom_ce}, 32'h1);
    check("rel_addr0", rom_addr, 32'h0);
    run1();
    check("rel_addr4", rom_addr, 32'h4);
    check("rel_idpc0", id_pc, 32'h0);
    check("rel_idv", {31'b0, id_valid}, 32'h1);
    run1();
    check("rel_addr8", rom_addr, 32'h8);
    check("rel_idpc4", id_pc, 32'h4);
    run1();
    run1();
    check("pre_stall_addr", rom_addr, 32'h10);

    // Stall bubble at 0x10
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
      check("stall_addr", rom_addr, 32'h10);
      check("stall_nop", id_inst, NOP_INST);
      check("stall_v", {31'b0, id_valid}, 32'h0);
    end
    run1();
    check("resume_idpc", id_pc, 32'h10);
    check("resume_v", {31'b0, id_valid}, 32'h1);

    // Branch with delay slot from 0x0C
    cyc(0, 0, 0, 1, 32'h0C, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, 32'h100);
    check("br_slot_pc", id_pc, 32'h0C);
    check("br_slot_v", {31'b0, id_valid}, 32'h1);
    run1();
    check("br_tgt_pc", id_pc, 32'h100);
    run1();
    check("br_next_pc", id_pc, 32'h104);

    // Flush beats stall and branch
    cyc(0, 1, 0, 1, 32'h180, 1, 32'h200);
    check("fl_addr", rom_addr, 32'h180);
    check("fl_v", {31'b0, id_valid}, 32'h0);
    run1();
    check("fl_idpc", id_pc, 32'h180);

    // Misaligned fetch
    cyc(0, 0, 0, 0, 32'h0, 1, 32'h102);
    run1();
    check("adel_pc", id_pc, 32'h102);
    check("adel_tag", {31'b0, id_adel}, 32'h1);
    check("adel_nop", id_inst, NOP_INST);

    // Wrap, then reset mid-run
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    check("wrap_top", rom_addr, 32'hFFFF_FFFC);
    run1();
    check("wrap_zero", rom_addr, 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
    check("mrst_ce", {31'b0, rom_ce}, 32'h0);
    check("mrst_v", {31'b0, id_valid}, 32'h0);
    run1();
    check("restart_ce", {31'b0, rom_ce}, 32'h1);
    check("restart_addr", rom_addr, RESET_PC);

    // Randomized traffic with a monotonic stall vector
    for (int i = 0; i < 3000; i++) begin
      bit          r, sif, sid, fl, br;
      logic [31:0] npc, tgt;
      r   = ($urandom_range(0, 99) < 1);
      fl  = ($urandom_range(0, 99) < 6);
      sif = ($urandom_range(0, 99) < 20);
      sid = sif && ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 99) < 15);
      npc = $urandom;
      tgt = $urandom;
      if ($urandom_range(0, 9) != 0) npc[1:0] = 2'b00;
      if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
      cyc(r, sif, sid, fl, npc, br, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
